// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// Owner state encoding, per-port control bundle, counter sizing.
package dmem_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic req;
    logic we;
    logic lock;
  } mctl_t;

  // Hold counter is clog2(MAX_HOLD) wide, but never narrower than one bit.
  function automatic int hold_w(input int max_hold);
    return (max_hold > 2) ? $clog2(max_hold) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not own last wins.
// Purely combinational.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic vld_o,
  output logic pick_o
);

  assign vld_o  = req0_i | req1_i;
  assign pick_o = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the core (M0) and loader/DMA (M1).
// Round-robin with optional burst lock, bounded to MAX_HOLD beats under contention.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic          m0_lock_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic          m1_lock_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_data_i
);

  localparam int            HW       = hold_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

  arb_state_e          state_q, state_d;
  logic                last_q, last_d;
  logic [HW-1:0]       hold_q, hold_d;

  mctl_t [1:0]         ctl;
  logic  [1:0][AW-1:0] addr;
  logic  [1:0][DW-1:0] wdata;
  logic  [1:0][DW-1:0] rdata_q;
  logic  [1:0]         rvalid_q;
  logic  [1:0]         gnt;
  logic  [1:0]         rd_gnt;

  logic own_vld, own, own_req, own_lock, oth_req;
  logic pick_vld, pick;

  assign ctl[0]   = '{req: m0_req_i, we: m0_we_i, lock: m0_lock_i};
  assign ctl[1]   = '{req: m1_req_i, we: m1_we_i, lock: m1_lock_i};
  assign addr[0]  = m0_addr_i;
  assign addr[1]  = m1_addr_i;
  assign wdata[0] = m0_wdata_i;
  assign wdata[1] = m1_wdata_i;

  assign own_vld  = (state_q != ST_IDLE);
  assign own      = (state_q == ST_OWN1);
  assign own_req  = ctl[own].req;
  assign own_lock = ctl[own].lock;
  assign oth_req  = ctl[~own].req;

  // Gated by reset so a beat presented in the reset cycle can never write.
  assign gnt[0] = rst_i & (state_q == ST_OWN0) & ctl[0].req;
  assign gnt[1] = rst_i & (state_q == ST_OWN1) & ctl[1].req;

  always_comb begin
    for (int p = 0; p < 2; p++) rd_gnt[p] = gnt[p] & ~ctl[p].we;
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_rdata_o  = rdata_q[0];
  assign m1_rdata_o  = rdata_q[1];

  assign mem_we_o   = |(gnt & {ctl[1].we, ctl[0].we});
  assign mem_addr_o = own_vld ? addr[own]  : '0;
  assign mem_data_o = own_vld ? wdata[own] : '0;

  rr_arb2 u_rr (
    .req0_i (ctl[0].req),
    .req1_i (ctl[1].req),
    .last_i (last_q),
    .vld_o  (pick_vld),
    .pick_o (pick)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    if (gnt[0])      last_d = 1'b0;
    else if (gnt[1]) last_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (pick_vld) state_d = pick ? ST_OWN1 : ST_OWN0;
      end
      ST_OWN0, ST_OWN1: begin
        if (own_req && own_lock && !oth_req) begin
          state_d = state_q;
        end else if (own_req && own_lock && oth_req && (hold_q < HOLD_LIM)) begin
          hold_d = hold_q + HW'(1);
        end else begin
          // Release: hand straight to the other port, no idle bubble.
          hold_d = '0;
          if (oth_req)       state_d = own ? ST_OWN0 : ST_OWN1;
          else if (!own_req) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      hold_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      rvalid_q <= rd_gnt;
      for (int p = 0; p < 2; p++)
        if (rd_gnt[p]) rdata_q[p] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem and a read-data scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem  [0:255];
  logic [31:0] smem [0:255];
  logic [31:0] q0[$], q1[$];
  int          checks = 0, failures = 0;
  int          beat;
  logic        e0, e1;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_data_i(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    chk("no_double_gnt", {31'b0, m0_gnt & m1_gnt}, 32'd0);
    if (m0_rvalid) begin
      if (q0.size() == 0) chk("rvalid0_unexpected", {31'b0, m0_rvalid}, 32'd0);
      else chk("sb_rdata0", m0_rdata, q0.pop_front());
    end
    if (m1_rvalid) begin
      if (q1.size() == 0) chk("rvalid1_unexpected", {31'b0, m1_rvalid}, 32'd0);
      else chk("sb_rdata1", m1_rdata, q1.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'hA500_0000 | 32'(i);
      smem[i] = 32'hA500_0000 | 32'(i);
    end
    rst_i = 1'b0;
    {m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock} = '0;
    m0_addr = 32'h40; m1_addr = 32'h44; m0_wdata = '0; m1_wdata = '0;
    m0_req = 1'b1; m1_req = 1'b1;
    tick(); tick();

    // Reset state (both requesting throughout reset)
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_gnt1", m1_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rvalid0", m0_rvalid, 0);
    chk("rst_rvalid1", m1_rvalid, 0);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_rdata1", m1_rdata, 0);

    // Both request at reset exit: M0 first, then strict alternation
    rst_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      e0 = (i > 0) && ((i - 1) % 2 == 0);
      e1 = (i > 0) && ((i - 1) % 2 == 1);
      chk($sformatf("alt_gnt0_%0d", i), m0_gnt, e0);
      chk($sformatf("alt_gnt1_%0d", i), m1_gnt, e1);
      if (e0) q0.push_back(smem[16]);
      if (e1) q1.push_back(smem[17]);
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();

    // M0 read 0x10 alone from IDLE
    m0_addr = 32'h10; m0_we = 1'b0; m0_req = 1'b1;
    #1 chk("rd_c0_gnt", m0_gnt, 0);
    tick();
    chk("rd_c1_gnt", m0_gnt, 1);
    chk("rd_c1_addr", mem_addr, 32'h10);
    q0.push_back(smem[4]);
    tick();
    m0_req = 1'b0;
    #1 chk("rd_c2_rvalid", m0_rvalid, 1);
    chk("rd_c2_rdata", m0_rdata, smem[4]);
    chk("rd_c2_gnt", m0_gnt, 0);
    tick();
    chk("rd_c3_idle_addr", mem_addr, 0);
    chk("rd_c3_rvalid", m0_rvalid, 0);

    // M0 writes 0x20, M1 reads it back
    m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hDEADBEEF; m0_req = 1'b1;
    #1 chk("wr_c0_gnt", m0_gnt, 0);
    tick();
    chk("wr_c1_gnt", m0_gnt, 1);
    chk("wr_c1_we", mem_we, 1);
    chk("wr_c1_data", mem_wdata, 32'hDEADBEEF);
    smem[8] = 32'hDEADBEEF;
    tick();
    m0_req = 1'b0; m0_we = 1'b0;
    #1 chk("wr_no_rvalid", m0_rvalid, 0);
    tick();
    m1_we = 1'b0; m1_addr = 32'h20; m1_req = 1'b1;
    #1 chk("m1rd_c0_gnt", m1_gnt, 0);
    tick();
    chk("m1rd_c1_gnt", m1_gnt, 1);
    q1.push_back(smem[8]);
    tick();
    m1_req = 1'b0;
    #1 chk("m1rd_data", m1_rdata, 32'hDEADBEEF);
    tick();

    // M1 locked 12-beat write burst while M0 waits: 8 beats, M0 once, 4 more
    m1_we = 1'b1; m1_lock = 1'b1; m1_req = 1'b1; beat = 0;
    m1_addr = 32'h80; m1_wdata = 32'hB000_0000;
    #1 chk("bur_c0_gnt", m1_gnt, 0);
    tick();
    m0_we = 1'b1; m0_addr = 32'h60; m0_wdata = 32'h0000_1234; m0_req = 1'b1;
    for (int j = 0; j < 13; j++) begin
      if (j == 9) m0_req = 1'b0;
      m1_addr  = 32'h80 + 32'(beat) * 4;
      m1_wdata = 32'hB000_0000 + 32'(beat);
      #1;
      e0 = (j == 8);
      e1 = !e0;
      chk($sformatf("bur_gnt0_%0d", j), m0_gnt, e0);
      chk($sformatf("bur_gnt1_%0d", j), m1_gnt, e1);
      if (e1) begin smem[32 + beat] = m1_wdata; beat++; end
      if (e0) smem[24] = 32'h0000_1234;
      tick();
    end
    m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0; m0_we = 1'b0;
    tick(); tick();

    // Read back burst beat 7 (M0) and M0's write (M1); M0 wins the tie
    m0_addr = 32'h9C; m1_addr = 32'h60; m0_req = 1'b1; m1_req = 1'b1;
    #1 chk("rb_c0_gnt0", m0_gnt, 0);
    tick();
    chk("rb_c1_gnt0", m0_gnt, 1);
    chk("rb_c1_gnt1", m1_gnt, 0);
    q0.push_back(smem[39]);
    tick();
    m0_req = 1'b0;
    #1 chk("rb_c2_gnt1", m1_gnt, 1);
    q1.push_back(smem[24]);
    tick();
    m1_req = 1'b0;
    tick(); tick();
    chk("rb_m0_data", m0_rdata, smem[39]);
    chk("rb_m1_data", m1_rdata, smem[24]);

    // Reset mid-burst with a write presented
    m1_we = 1'b1; m1_lock = 1'b1; m1_addr = 32'hC0; m1_wdata = 32'h0000_CAFE; m1_req = 1'b1;
    #1 chk("mrst_c0_gnt", m1_gnt, 0);
    tick();
    chk("mrst_c1_gnt", m1_gnt, 1);
    smem[48] = 32'h0000_CAFE;
    tick();
    m1_addr = 32'hC4; m1_wdata = 32'h0000_0BAD; rst_i = 1'b0;
    #1 chk("mrst_gnt", m1_gnt, 0);
    chk("mrst_we", mem_we, 0);
    tick();
    rst_i = 1'b1;
    #1 chk("mrst_post_gnt", m1_gnt, 0);
    chk("mrst_post_we", mem_we, 0);
    chk("mrst_post_addr", mem_addr, 0);
    chk("mrst_post_rvalid0", m0_rvalid, 0);
    chk("mrst_post_rvalid1", m1_rvalid, 0);
    chk("mrst_post_rdata0", m0_rdata, 0);
    chk("mrst_post_rdata1", m1_rdata, 0);
    tick();
    chk("mrst_regnt", m1_gnt, 1);
    smem[49] = 32'h0000_0BAD;
    tick();
    m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0;
    tick(); tick();

    // Owner drops req while holding lock, other idle
    m0_we = 1'b1; m0_lock = 1'b1; m0_addr = 32'hA0; m0_wdata = 32'h0000_5A5A; m0_req = 1'b1;
    #1 chk("drop_c0_gnt", m0_gnt, 0);
    tick();
    chk("drop_c1_gnt", m0_gnt, 1);
    smem[40] = 32'h0000_5A5A;
    tick();
    m0_req = 1'b0;
    #1 chk("drop_gnt", m0_gnt, 0);
    chk("drop_we", mem_we, 0);
    chk("drop_own_addr", mem_addr, 32'hA0);
    tick();
    chk("drop_idle_addr", mem_addr, 0);
    m0_lock = 1'b0; m0_we = 1'b0;

    // M1 reads back the locked write and the post-reset beat
    m1_addr = 32'hA0; m1_req = 1'b1;
    tick();
    chk("fin_gnt1_a", m1_gnt, 1);
    q1.push_back(smem[40]);
    tick();
    m1_addr = 32'hC4;
    #1 chk("fin_gnt1_b", m1_gnt, 1);
    q1.push_back(smem[49]);
    tick();
    m1_req = 1'b0;

    for (int k = 0; k < 10 && (q0.size() != 0 || q1.size() != 0); k++) tick();
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
